// File: rtl/mmio_input_reader.sv
// Memory-mapped read port for board switches and push-buttons: two-flop synchronizers,
// per-key debounce, sticky read-to-clear press events and 1-cycle registered read data.
module mmio_input_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned NUM_SW          = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         MemoryAdr,
    input  logic                ren,
    output logic [31:0]         rdata,
    output logic                rvalid,
    output logic                key_pending,
    input  logic [NUM_SW-1:0]   sw,
    input  logic [NUM_KEYS-1:0] key_n
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [31:0] AdrSw     = 32'h8000_0068;
    localparam logic [31:0] AdrKeyEv  = 32'h8000_006C;
    localparam logic [31:0] AdrKeyLvl = 32'h8000_0070;

    logic [NUM_SW-1:0]              sw_meta_q, sw_sync_q;
    logic [NUM_KEYS-1:0]            key_meta_q, key_sync_q;
    logic [NUM_KEYS-1:0]            key_lvl;
    // stable_q holds the debounced level with 1 = pressed
    logic [NUM_KEYS-1:0]            stable_q, stable_d, stable_dly_q;
    logic [NUM_KEYS-1:0][CntW-1:0]  cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]            keyev_q, keyev_d;
    logic [NUM_KEYS-1:0]            press;
    logic [31:0]                    rdata_q, rdata_d;
    logic                           rvalid_q;
    logic                           rd_keyev;

    assign key_lvl = ~key_sync_q;
    assign press   = stable_q & ~stable_dly_q;

    always_comb begin
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            cnt_d[i]    = '0;
            stable_d[i] = stable_q[i];
            if (key_lvl[i] != stable_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    stable_d[i] = key_lvl[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end
            end
        end
    end

    // A press landing on the same edge as a clearing read survives the clear.
    assign rd_keyev = ren && (MemoryAdr == AdrKeyEv);
    assign keyev_d  = rd_keyev ? press : (keyev_q | press);

    always_comb begin
        rdata_d = '0;
        case (MemoryAdr)
            AdrSw:     rdata_d[NUM_SW-1:0]   = sw_sync_q;
            AdrKeyEv:  rdata_d[NUM_KEYS-1:0] = keyev_q;
            AdrKeyLvl: rdata_d[NUM_KEYS-1:0] = stable_q;
            default:   rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            key_meta_q   <= '1;
            key_sync_q   <= '1;
            stable_q     <= '0;
            stable_dly_q <= '0;
            cnt_q        <= '0;
            keyev_q      <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            sw_meta_q    <= sw;
            sw_sync_q    <= sw_meta_q;
            key_meta_q   <= key_n;
            key_sync_q   <= key_meta_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            keyev_q      <= keyev_d;
            rvalid_q     <= ren;
            if (ren) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign rdata       = rdata_q;
    assign rvalid      = rvalid_q;
    assign key_pending = |keyev_q;

endmodule

// File: doc/mmio_input_reader.md
# mmio_input_reader

Memory-mapped input peripheral that lets the CPU read board switches and push-buttons through load instructions, the read-side counterpart of the display write port at 0x8000_0064. It synchronizes and debounces the raw inputs, latches key-press events into a sticky status register that clears on read, and returns read data one cycle after a read strobe. It sits on the same data-memory address bus as the display write port and claims the addresses immediately above it.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronized key level must differ from its stable value before it is accepted; minimum 1.
- NUM_KEYS, 4: number of active-low push-buttons; 1..32.
- NUM_SW, 10: number of slide switches; 1..32.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- MemoryAdr  input  32  CPU data address.
- ren  input  1  read strobe; sampled with MemoryAdr on the same edge.
- rdata  output  32  registered read data.
- rvalid  output  1  one-cycle pulse marking rdata valid.
- key_pending  output  1  OR of all sticky key-event bits.
- sw  input  NUM_SW  raw asynchronous switch levels.
- key_n  input  NUM_KEYS  raw asynchronous buttons; 0 = pressed.

## Operation
- Address map:
  - 0x8000_0068 SW: zero-extended synchronized switches.
  - 0x8000_006C KEYEV: sticky press events, bit i = key i. Read-to-clear.
  - 0x8000_0070 KEYLVL: debounced level, bit i = 1 when key i is pressed.
- Any other address with ren=1 returns rdata=0 with rvalid=1 and has no side effects. Upper unused bits always read 0.
- Synchronizer: every sw and key_n bit passes through two flops. The key sync flops reset to 1 (released); the sw sync flops reset to 0.
- Debounce, one instance per key:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If the synced level equals stable, the counter is 0.
  - Otherwise the counter increments each cycle.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 while the levels still differ: stable takes the synced level and the counter returns to 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable, and the counter restarts from 0 on the next difference.
- Event latch: a stable transition from released to pressed sets KEYEV[i] on the following edge. Release transitions set nothing.
- Read of KEYEV: rdata captures the pre-clear value, and all bits that were set are cleared on that same edge.
- Set/clear collision: a press event that sets a bit on the same edge as a clearing read wins. That bit is set after the edge and is not reported in that read's rdata.
- key_pending = |KEYEV (registered bits, combinational OR).
- Reset clears counters, KEYEV, rdata and rvalid to 0 and forces stable to released. Reset asserted mid-debounce discards the partial count. Reset asserted during a read suppresses rvalid on the next cycle.

## Timing
- Read latency is 1 cycle: ren=1 at edge N gives rvalid=1 and rdata valid during cycle N+1. rvalid is 0 on every other cycle.
- Back-to-back reads are allowed every cycle, with one response per request and no stall.
- Key input to stable level: 2 sync cycles plus DEBOUNCE_CYCLES cycles.
- Stable level to KEYEV bit: 1 further cycle.
- Switch input to visible SW read data: 2 cycles after the input changes, then the 1-cycle read latency.
- Reset values: rdata=0, rvalid=0, key_pending=0.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4, NUM_KEYS=4, NUM_SW=10.
- Reset and SW read:
  - Assert rst for 2 cycles, then set sw=10'h2A5 and wait 3 cycles.
  - Read 0x8000_0068 -> next cycle rvalid=1, rdata=0x0000_02A5.
  - Read 0x8000_006C immediately after reset -> 0.
- Clean press:
  - Drive key_n[2] low and hold it.
  - KEYLVL reads 0x4 no earlier than 6 cycles after the input change.
  - key_pending rises 1 cycle after the stable change.
  - Read KEYEV -> 0x4; a second read the next cycle -> 0; key_pending drops.
- Glitch rejection:
  - Pulse key_n[0] low for 3 cycles, then high for 1 cycle, and repeat this 5 times.
  - Result -> KEYLVL=0, KEYEV=0, key_pending stays 0.
- Set/clear collision:
  - Have KEYEV=0x1 and time a key 3 press so its event sets on the same edge as a KEYEV read.
  - Result -> that read returns 0x1; the next read returns 0x8.
- Unmapped and back-to-back reads:
  - Issue reads to 0x8000_0064, 0x8000_0068 and 0x0000_0070 on 3 consecutive cycles.
  - Result -> 3 consecutive rvalid pulses with rdata 0, SW value, 0; KEYEV is unaffected.
- Reset mid-debounce:
  - Press key 1, and assert rst 3 cycles after the synced level changes.
  - Result -> KEYLVL=0 after reset. With the key still held, a new full 2+4 cycle window elapses before KEYLVL=0x2 and KEYEV=0x2.
